// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage and its consumers.
//   - fetchStateT : fetch FSM states (IDLE, REQ, WAIT)
//   - bufEntryT   : one instruction buffer entry {pc, instr}
//   - INSTR_W / FIELD_W and the bit positions of the four instruction
//     fields (opcode, one, two, three); decode uses the same constants so
//     both sides agree on where each field lives.
//   - getField()  : extracts one FIELD_W-wide field at a given LSB.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   localparam int INSTR_W    = 16;
   localparam int FIELD_W    = 4;
   localparam int NUM_FIELDS = INSTR_W / FIELD_W;

   // LSB of each field inside the instruction word
   localparam int OPCODE_LSB = 12;
   localparam int ONE_LSB    = 8;
   localparam int TWO_LSB    = 4;
   localparam int THREE_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetchStateT;

   typedef struct packed {
      logic [INSTR_W-1:0] pc;
      logic [INSTR_W-1:0] instr;
   } bufEntryT;

   function automatic logic [FIELD_W-1:0] getField(input logic [INSTR_W-1:0] instr,
                                                   input int                 lsb);
      return instr[lsb +: FIELD_W];
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Small FIFO of fetched {pc, instr} entries sitting between the memory
// response path and the IF/ID register.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write pushData at the tail
//   pushData   : entry to write
//   pop        : advance the head (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   headData   : current head entry (combinational, valid when !empty)
//   count      : number of live entries
//   empty      : count == 0
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module fetch_buffer
   import fetch_stage_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  bufEntryT         pushData,
   input  logic             pop,
   input  logic             flush,
   output bufEntryT         headData,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   // Kept as a plain register array: the head must be readable in the same
   // cycle it is popped into the IF/ID register, so a registered read port
   // would cost an extra cycle of fetch latency.
   bufEntryT         memArray [DEPTH];
   logic [PTR_W-1:0] rdPtrReg;
   logic [PTR_W-1:0] wrPtrReg;
   logic [CNT_W-1:0] countReg;
   logic             doPush;
   logic             doPop;

   assign empty    = (countReg == '0);
   assign count    = countReg;
   assign headData = memArray[rdPtrReg];

   // Flush cancels everything else in the same cycle. The fetch FSM already
   // reserves a slot before issuing, so the full check only guards misuse.
   assign doPop  = pop && !empty && !flush;
   assign doPush = push && !flush && ((countReg != CNT_W'(DEPTH)) || doPop);

   always_ff @(posedge clk) begin
      if (doPush) begin
         memArray[wrPtrReg] <= pushData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtrReg <= '0;
         wrPtrReg <= '0;
         countReg <= '0;
      end else if (flush) begin
         rdPtrReg <= '0;
         wrPtrReg <= '0;
         countReg <= '0;
      end else begin
         if (doPush) begin
            wrPtrReg <= wrPtrReg + PTR_W'(1);
         end
         if (doPop) begin
            rdPtrReg <= rdPtrReg + PTR_W'(1);
         end
         if (doPush && !doPop) begin
            countReg <= countReg + CNT_W'(1);
         end else if (doPop && !doPush) begin
            countReg <= countReg - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage plus IF/ID register of the 16-bit pipeline.
// Issues one word request at a time, buffers responses, and presents one
// clean in-order instruction per cycle to decode, split into four fields.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_req/addr   : single-cycle request strobe and word address
//   imem_rdata/valid: in-order response, at least one cycle after request
//   redirect/_pc    : taken branch/jump; flush and refetch from redirect_pc
//   stall           : decode cannot accept; ID outputs hold
//   id_valid/id_pc  : live-instruction flag and its address
//   id_opcode/one/two/three : instr[15:12] / [11:8] / [7:4] / [3:0]
// Parameters: RESET_PC (fetch address after reset), BUF_DEPTH (buffer
// entries, power of two, at least 2).
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC  = 16'h0000,
   parameter int                 BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [INSTR_W-1:0] imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   input  logic               redirect,
   input  logic [INSTR_W-1:0] redirect_pc,
   input  logic               stall,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_pc,
   output logic [FIELD_W-1:0] id_opcode,
   output logic [FIELD_W-1:0] id_one,
   output logic [FIELD_W-1:0] id_two,
   output logic [FIELD_W-1:0] id_three
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   fetchStateT         stateReg;
   fetchStateT         stateNext;
   logic [INSTR_W-1:0] fetchPcReg;
   logic [INSTR_W-1:0] fetchPcNext;
   logic [INSTR_W-1:0] reqPcReg;     // address of the request in flight
   logic [INSTR_W-1:0] reqPcNext;
   logic               dropReg;      // in-flight response belongs to a flushed path
   logic               dropNext;

   logic               bufPush;
   logic               bufPop;
   logic               bufEmpty;
   logic [CNT_W-1:0]   bufCount;
   bufEntryT           bufHead;
   bufEntryT           bufPushEntry;

   logic               idValidReg;
   logic [INSTR_W-1:0] idPcReg;
   logic [INSTR_W-1:0] idInstrReg;
   logic [FIELD_W-1:0] idField [NUM_FIELDS];

   // ---------------------------------------------------------------------
   // Instruction buffer
   // ---------------------------------------------------------------------
   assign bufPushEntry = '{pc: reqPcReg, instr: imem_rdata};

   // Nothing leaves the buffer while decode is stalled or the path is being
   // flushed.
   assign bufPop = !stall && !bufEmpty && !redirect;

   fetch_buffer #(
      .DEPTH    (BUF_DEPTH)
   ) u_fetchBuffer (
      .clk      (clk),
      .rst      (rst),
      .push     (bufPush),
      .pushData (bufPushEntry),
      .pop      (bufPop),
      .flush    (redirect),
      .headData (bufHead),
      .count    (bufCount),
      .empty    (bufEmpty)
   );

   // ---------------------------------------------------------------------
   // Fetch FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg   <= IDLE;
         fetchPcReg <= RESET_PC;
         reqPcReg   <= RESET_PC;
         dropReg    <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         fetchPcReg <= fetchPcNext;
         reqPcReg   <= reqPcNext;
         dropReg    <= dropNext;
      end
   end

   // ---------------------------------------------------------------------
   // Fetch FSM: next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      stateNext   = stateReg;
      fetchPcNext = fetchPcReg;
      reqPcNext   = reqPcReg;
      dropNext    = dropReg;
      imem_req    = 1'b0;
      bufPush     = 1'b0;

      case (stateReg)
         IDLE: begin
            // Issuing only below full reserves the slot for the response,
            // since only one request is ever outstanding. On redirect the
            // new fetch address is not loaded yet, so wait one cycle.
            if (!redirect && (bufCount < CNT_W'(BUF_DEPTH))) begin
               stateNext = REQ;
            end
         end

         REQ: begin
            imem_req    = 1'b1;
            reqPcNext   = fetchPcReg;
            fetchPcNext = fetchPcReg + 16'd1;
            stateNext   = WAIT;
            // The request has already gone out; its response must be eaten.
            if (redirect) begin
               dropNext = 1'b1;
            end
         end

         WAIT: begin
            if (imem_valid) begin
               // A same-cycle redirect also discards this word, via the
               // buffer flush taking priority over the push.
               bufPush   = !dropReg;
               dropNext  = 1'b0;
               stateNext = IDLE;
            end else if (redirect) begin
               dropNext = 1'b1;
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase

      if (redirect) begin
         fetchPcNext = redirect_pc;
      end
   end

   assign imem_addr = fetchPcReg;

   // ---------------------------------------------------------------------
   // IF/ID register. Redirect clears the valid flag even under stall;
   // the stale fields may linger but are never marked valid.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idValidReg <= 1'b0;
         idPcReg    <= '0;
         idInstrReg <= '0;
      end else if (redirect) begin
         idValidReg <= 1'b0;
      end else if (!stall) begin
         if (!bufEmpty) begin
            idValidReg <= 1'b1;
            idPcReg    <= bufHead.pc;
            idInstrReg <= bufHead.instr;
         end else begin
            idValidReg <= 1'b0;
         end
      end
   end

   // Field split: field gi occupies bits [gi*FIELD_W +: FIELD_W]
   generate
      for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
         assign idField[gi] = getField(idInstrReg, gi * FIELD_W);
      end
   endgenerate

   assign id_valid  = idValidReg;
   assign id_pc     = idPcReg;
   assign id_opcode = idField[OPCODE_LSB / FIELD_W];
   assign id_one    = idField[ONE_LSB / FIELD_W];
   assign id_two    = idField[TWO_LSB / FIELD_W];
   assign id_three  = idField[THREE_LSB / FIELD_W];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. A small memory model answers each request
// after memLat cycles; the stimulus block walks a fixed cycle-numbered script
// (cycle 0 = the cycle in which reset is released) and checks outputs at the
// falling edge with hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        stall;
   logic        id_valid;
   logic [15:0] id_pc;
   logic [3:0]  id_opcode;
   logic [3:0]  id_one;
   logic [3:0]  id_two;
   logic [3:0]  id_three;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int memLat   = 1;
   int memCycle = 0;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } respT;
   respT respQ[$];

   fetch_stage #(
      .RESET_PC    (16'h0000),
      .BUF_DEPTH   (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_opcode   (id_opcode),
      .id_one      (id_one),
      .id_two      (id_two),
      .id_three    (id_three)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: address 0 holds 16'h1234, others a fixed pattern.
   function automatic logic [15:0] memData(input logic [15:0] a);
      if (a == 16'h0000) return 16'h1234;
      return a ^ 16'h9C00;
   endfunction

   // Memory model: responses in order, each memLat cycles after its request.
   initial begin
      imem_valid = 1'b0;
      imem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         memCycle++;
         imem_valid = 1'b0;
         if (respQ.size() > 0 && respQ[0].due == memCycle) begin
            imem_valid = 1'b1;
            imem_rdata = memData(respQ[0].addr);
            void'(respQ.pop_front());
         end
         if (imem_req === 1'b1 && rst === 1'b0) begin
            respQ.push_back('{addr: imem_addr, due: memCycle + memLat});
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic goTo(input int n);
      while (cyc < n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   function automatic logic [31:0] idInstr();
      return 32'({id_opcode, id_one, id_two, id_three});
   endfunction

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      stall       = 1'b0;

      // ---- reset values ----
      repeat (3) @(negedge clk);
      chk("rst_id_valid", 32'(id_valid), 0);
      chk("rst_id_pc", 32'(id_pc), 0);
      chk("rst_id_fields", idInstr(), 0);
      chk("rst_imem_req", 32'(imem_req), 0);
      chk("rst_imem_addr", 32'(imem_addr), 0);
      rst = 1'b0;
      cyc = 0;

      // ---- first fetch, L=1 ----
      goTo(1);
      chk("c1_req", 32'(imem_req), 1);
      chk("c1_addr", 32'(imem_addr), 0);
      goTo(2);
      chk("c2_req", 32'(imem_req), 0);
      goTo(3);
      chk("c3_id_valid", 32'(id_valid), 0);
      goTo(4);
      chk("c4_id_valid", 32'(id_valid), 1);
      chk("c4_id_pc", 32'(id_pc), 0);
      chk("c4_opcode", 32'(id_opcode), 1);
      chk("c4_one", 32'(id_one), 2);
      chk("c4_two", 32'(id_two), 3);
      chk("c4_three", 32'(id_three), 4);
      chk("c4_req", 32'(imem_req), 1);
      chk("c4_addr", 32'(imem_addr), 1);

      // ---- stall for cycles 4..9: ID holds, buffer fills, no third request ----
      stall = 1'b1;
      for (int c = 5; c <= 10; c++) begin
         goTo(c);
         chk("stall_id_valid", 32'(id_valid), 1);
         chk("stall_id_pc", 32'(id_pc), 0);
         chk("stall_id_instr", idInstr(), 'h1234);
         if (c == 7) begin
            chk("stall_req2", 32'(imem_req), 1);
            chk("stall_addr2", 32'(imem_addr), 2);
         end
         if (c >= 9) begin
            chk("stall_no_req3", 32'(imem_req), 0);
         end
      end
      stall = 1'b0;
      goTo(11);
      chk("c11_id_pc", 32'(id_pc), 1);
      chk("c11_id_valid", 32'(id_valid), 1);
      chk("c11_id_instr", idInstr(), 32'(memData(16'h0001)));
      chk("c11_req", 32'(imem_req), 0);
      goTo(12);
      chk("c12_id_pc", 32'(id_pc), 2);
      chk("c12_id_valid", 32'(id_valid), 1);
      chk("c12_req", 32'(imem_req), 1);
      chk("c12_addr", 32'(imem_addr), 3);
      goTo(13);
      chk("c13_id_valid", 32'(id_valid), 0);
      goTo(14);
      chk("c14_id_valid", 32'(id_valid), 0);
      memLat = 3;

      // ---- redirect to 0040 while in WAIT, L=3, decode stalled ----
      goTo(15);
      chk("c15_id_pc", 32'(id_pc), 3);
      chk("c15_id_valid", 32'(id_valid), 1);
      chk("c15_req", 32'(imem_req), 1);
      chk("c15_addr", 32'(imem_addr), 4);
      stall = 1'b1;
      goTo(16);
      chk("c16_id_valid_held", 32'(id_valid), 1);
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      goTo(17);
      redirect = 1'b0;
      stall    = 1'b0;
      chk("c17_id_valid", 32'(id_valid), 0);
      chk("c17_req", 32'(imem_req), 0);
      goTo(18);
      chk("c18_req", 32'(imem_req), 0);
      goTo(19);
      chk("c19_req", 32'(imem_req), 0);
      goTo(20);
      chk("c20_req", 32'(imem_req), 1);
      chk("c20_addr", 32'(imem_addr), 'h40);
      chk("c20_id_valid", 32'(id_valid), 0);
      goTo(21);
      chk("c21_id_valid", 32'(id_valid), 0);
      goTo(25);
      chk("c25_id_valid", 32'(id_valid), 1);
      chk("c25_id_pc", 32'(id_pc), 'h40);
      chk("c25_id_instr", idInstr(), 32'(memData(16'h0040)));
      chk("c25_addr", 32'(imem_addr), 'h41);
      goTo(30);
      chk("c30_id_valid", 32'(id_valid), 1);
      chk("c30_id_pc", 32'(id_pc), 'h41);
      chk("c30_req", 32'(imem_req), 1);
      chk("c30_addr", 32'(imem_addr), 'h42);

      // ---- redirect to FFFF together with imem_valid, under stall ----
      stall = 1'b1;
      goTo(33);
      chk("c33_id_held", 32'(id_pc), 'h41);
      chk("c33_id_valid", 32'(id_valid), 1);
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      goTo(34);
      redirect = 1'b0;
      chk("c34_id_valid", 32'(id_valid), 0);
      chk("c34_req", 32'(imem_req), 0);
      stall  = 1'b0;
      memLat = 1;
      goTo(35);
      chk("c35_id_valid", 32'(id_valid), 0);
      chk("c35_req", 32'(imem_req), 1);
      chk("c35_addr", 32'(imem_addr), 'hFFFF);
      goTo(38);
      chk("c38_id_valid", 32'(id_valid), 1);
      chk("c38_id_pc", 32'(id_pc), 'hFFFF);
      chk("c38_id_instr", idInstr(), 32'(memData(16'hFFFF)));
      chk("c38_addr_wrap", 32'(imem_addr), 0);
      chk("c38_req", 32'(imem_req), 1);
      goTo(40);
      memLat = 4;
      goTo(41);
      chk("c41_id_pc_wrap", 32'(id_pc), 0);
      chk("c41_id_instr", idInstr(), 'h1234);
      chk("c41_addr", 32'(imem_addr), 1);

      // ---- reset while in WAIT; late response after release ----
      goTo(42);
      rst = 1'b1;
      #1;
      chk("c42_async_fields", idInstr(), 0);
      goTo(43);
      chk("c43_id_valid", 32'(id_valid), 0);
      chk("c43_id_pc", 32'(id_pc), 0);
      chk("c43_req", 32'(imem_req), 0);
      chk("c43_addr", 32'(imem_addr), 0);
      goTo(45);
      rst    = 1'b0;
      memLat = 1;
      goTo(46);
      chk("c46_req", 32'(imem_req), 1);
      chk("c46_addr", 32'(imem_addr), 0);
      goTo(47);
      chk("c47_id_valid", 32'(id_valid), 0);
      goTo(48);
      chk("c48_id_valid", 32'(id_valid), 0);
      goTo(49);
      chk("c49_id_valid", 32'(id_valid), 1);
      chk("c49_id_pc", 32'(id_pc), 0);
      chk("c49_id_instr", idInstr(), 'h1234);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
